// File: rtl/tri_counter_sequencer_if.sv
// Request/response bundle between requesters and the ternary-counter sequencer.
// Requesters act as master; the sequencer is the slave.
interface tri_counter_sequencer_if #(
    parameter int unsigned RPT_W = 4
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [6:0]       req_word0;
    logic [6:0]       req_word1;
    logic [RPT_W-1:0] req_rpt0;
    logic [RPT_W-1:0] req_rpt1;
    logic             rsp_valid;
    logic             rsp_id;
    logic [3:0]       rsp_data;
    logic             rsp_last;

    modport master (
        output req_valid, req_word0, req_word1, req_rpt0, req_rpt1,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_last
    );

    modport slave (
        input  req_valid, req_word0, req_word1, req_rpt0, req_rpt1,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_last
    );
endinterface

// File: rtl/tri_counter_sequencer.sv
// Owns the ternary load counter's io_in bus: plays the init pattern after reset,
// then runs setup/cycle/capture ops for two round-robin requesters.
module tri_counter_sequencer #(
    parameter int unsigned SETUP_CYC  = 4,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned RPT_W      = 4,
    parameter logic [6:0]  INIT_WORD  = 7'h00
) (
    input  logic                          clk,
    input  logic                          rst,
    tri_counter_sequencer_if.slave        rq,
    output logic [7:0]                    ctr_in,
    input  logic [3:0]                    ctr_out,
    output logic                          busy
);
    typedef enum logic [2:0] {
        ST_INIT_S, ST_INIT_C, ST_IDLE, ST_SETUP, ST_STROBE, ST_CAPT
    } state_t;

    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);

    state_t           state, state_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic [6:0]       word, word_nxt;
    logic [RPT_W-1:0] rem, rem_nxt;
    logic             id, id_nxt;
    logic             rr_last, rr_last_nxt;
    logic [7:0]       ctr_in_nxt;
    logic             busy_nxt;
    logic             rsp_valid_nxt, rsp_id_nxt, rsp_last_nxt;
    logic [3:0]       rsp_data_nxt;
    logic [1:0]       grant;

    // Contention goes to the requester not granted last; rr_last moves only on accept.
    always_comb begin
        grant = rq.req_valid;
        if (rq.req_valid == 2'b11)
            grant = rr_last ? 2'b01 : 2'b10;
        rq.req_ready = (state == ST_IDLE) ? grant : 2'b00;
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        word_nxt      = word;
        rem_nxt       = rem;
        id_nxt        = id;
        rr_last_nxt   = rr_last;
        ctr_in_nxt    = ctr_in;
        rsp_valid_nxt = 1'b0;
        rsp_id_nxt    = rq.rsp_id;
        rsp_data_nxt  = rq.rsp_data;
        rsp_last_nxt  = 1'b0;
        case (state)
            ST_INIT_S: begin
                ctr_in_nxt = {1'b0, INIT_WORD};
                if (cnt == '0) begin
                    state_nxt  = ST_INIT_C;
                    cnt_nxt    = STROBE_LD;
                    ctr_in_nxt = {1'b1, INIT_WORD};
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ST_INIT_C: begin
                if (cnt == '0) begin
                    state_nxt  = ST_IDLE;
                    word_nxt   = INIT_WORD;
                    ctr_in_nxt = {1'b0, INIT_WORD};
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ST_IDLE: begin
                if (rq.req_ready != 2'b00) begin
                    id_nxt      = rq.req_ready[1];
                    rr_last_nxt = rq.req_ready[1];
                    word_nxt    = rq.req_ready[1] ? rq.req_word1 : rq.req_word0;
                    rem_nxt     = rq.req_ready[1] ? rq.req_rpt1 : rq.req_rpt0;
                    state_nxt   = ST_SETUP;
                    cnt_nxt     = SETUP_LD;
                    ctr_in_nxt  = {1'b0, word_nxt};
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_nxt  = ST_STROBE;
                    cnt_nxt    = STROBE_LD;
                    ctr_in_nxt = {1'b1, word};
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ST_STROBE: begin
                if (cnt == '0) begin
                    state_nxt  = ST_CAPT;
                    ctr_in_nxt = {1'b0, word};
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ST_CAPT: begin
                rsp_valid_nxt = 1'b1;
                rsp_id_nxt    = id;
                rsp_data_nxt  = ctr_out;
                rsp_last_nxt  = (rem == '0);
                if (rem == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    rem_nxt   = rem - 1'b1;
                    state_nxt = ST_SETUP;
                    cnt_nxt   = SETUP_LD;
                end
            end
            default: state_nxt = ST_INIT_S;
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_INIT_S;
            cnt          <= SETUP_LD;
            word         <= INIT_WORD;
            rem          <= '0;
            id           <= 1'b0;
            rr_last      <= 1'b1;
            ctr_in       <= '0;
            busy         <= 1'b1;
            rq.rsp_valid <= 1'b0;
            rq.rsp_id    <= 1'b0;
            rq.rsp_data  <= '0;
            rq.rsp_last  <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            word         <= word_nxt;
            rem          <= rem_nxt;
            id           <= id_nxt;
            rr_last      <= rr_last_nxt;
            ctr_in       <= ctr_in_nxt;
            busy         <= busy_nxt;
            rq.rsp_valid <= rsp_valid_nxt;
            rq.rsp_id    <= rsp_id_nxt;
            rq.rsp_data  <= rsp_data_nxt;
            rq.rsp_last  <= rsp_last_nxt;
        end
    end
endmodule

// File: tb/tb_tri_counter_sequencer.sv
// Directed bench for tri_counter_sequencer: default-timing instance against a
// small ternary-counter model, plus a 1/1-cycle instance for the short op.
module tb_tri_counter_sequencer;
    logic       clk;
    logic       rst;
    logic [7:0] ctr_in, fast_ctr_in;
    logic [3:0] ctr_out;
    logic [3:0] fast_out;
    logic       busy, fast_busy;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned n_fail = 0;

    tri_counter_sequencer_if #(.RPT_W(4)) bus ();
    tri_counter_sequencer_if #(.RPT_W(4)) fbus ();

    tri_counter_sequencer #(
        .SETUP_CYC(4), .STROBE_CYC(4), .RPT_W(4), .INIT_WORD(7'h00)
    ) dut (
        .clk(clk), .rst(rst), .rq(bus.slave),
        .ctr_in(ctr_in), .ctr_out(ctr_out), .busy(busy)
    );

    tri_counter_sequencer #(
        .SETUP_CYC(1), .STROBE_CYC(1), .RPT_W(4), .INIT_WORD(7'h00)
    ) dut_fast (
        .clk(clk), .rst(rst), .rq(fbus.slave),
        .ctr_in(fast_ctr_in), .ctr_out(fast_out), .busy(fast_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter model: 7'h3E counts up, 7'h7F loads zero, on a rising cycle bit.
    logic [3:0] model_q;
    logic       prev7;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q <= 4'h3;
            prev7   <= 1'b0;
        end else begin
            prev7 <= ctr_in[7];
            if (ctr_in[7] && !prev7) begin
                case (ctr_in[6:0])
                    7'h3E:   model_q <= model_q + 4'd1;
                    7'h7F:   model_q <= 4'h0;
                    default: ;
                endcase
            end
        end
    end
    assign ctr_out = model_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every clock: word changes only with the cycle bit low on both sides; ready one-hot-or-zero.
    logic [7:0] prev_ctr, prev_fctr;
    logic       prev_rst;
    initial begin
        prev_ctr  = '0;
        prev_fctr = '0;
        prev_rst  = 1'b1;
    end
    always @(negedge clk) begin
        if (!rst && !prev_rst && prev_ctr[6:0] != ctr_in[6:0])
            chk("order", 32'({prev_ctr[7], ctr_in[7]}), 32'd0);
        if (!rst && !prev_rst && prev_fctr[6:0] != fast_ctr_in[6:0])
            chk("order_fast", 32'({prev_fctr[7], fast_ctr_in[7]}), 32'd0);
        chk("ready_onehot", 32'(bus.req_ready & (bus.req_ready - 2'd1)), 32'd0);
        chk("ready_onehot_fast", 32'(fbus.req_ready & (fbus.req_ready - 2'd1)), 32'd0);
        prev_ctr  = ctr_in;
        prev_fctr = fast_ctr_in;
        prev_rst  = rst;
    end

    initial begin
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_word0 = 7'h00;
        bus.req_word1 = 7'h00;
        bus.req_rpt0  = 4'd0;
        bus.req_rpt1  = 4'd0;
        fbus.req_valid = 2'b00;
        fbus.req_word0 = 7'h00;
        fbus.req_word1 = 7'h00;
        fbus.req_rpt0  = 4'd0;
        fbus.req_rpt1  = 4'd0;
        fast_out = 4'h9;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctr_in", 32'(ctr_in), 32'h00);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_last", 32'(bus.rsp_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        // T1: init pattern, requests ignored while busy
        rst = 1'b0;
        bus.req_valid = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t1_init_s", 32'(ctr_in), 32'h00);
            chk("t1_ready0", 32'(bus.req_ready), 32'd0);
            chk("t1_busy", 32'(busy), 32'd1);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            chk("t1_init_c", 32'(ctr_in), 32'h80);
            chk("t1_no_rsp", 32'(bus.rsp_valid), 32'd0);
            if (i == 3) bus.req_valid = 2'b00;
            tick();
        end
        chk("t1_idle_ctr", 32'(ctr_in), 32'h00);
        chk("t1_busy_low", 32'(busy), 32'd0);

        // T2: requester 0 counts up five times
        bus.req_word0 = 7'h3E;
        bus.req_rpt0  = 4'd4;
        bus.req_valid = 2'b01;
        #1;
        chk("t2_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 2'b00;
        bus.req_word0 = 7'h11;
        bus.req_rpt0  = 4'd0;
        for (int op = 0; op < 5; op++) begin
            for (int i = 0; i < 4; i++) begin
                chk("t2_setup", 32'(ctr_in), 32'h3E);
                tick();
            end
            for (int i = 0; i < 4; i++) begin
                chk("t2_strobe", 32'(ctr_in), 32'hBE);
                tick();
            end
            chk("t2_capt_ctr", 32'(ctr_in), 32'h3E);
            chk("t2_capt_norsp", 32'(bus.rsp_valid), 32'd0);
            tick();
            chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("t2_rsp_id", 32'(bus.rsp_id), 32'd0);
            chk("t2_rsp_data", 32'(bus.rsp_data), 32'(4 + op));
            chk("t2_rsp_last", 32'(bus.rsp_last), (op == 4) ? 32'd1 : 32'd0);
        end
        chk("t2_busy_low", 32'(busy), 32'd0);
        tick();
        chk("t2_pulse_end", 32'(bus.rsp_valid), 32'd0);
        chk("t2_idle_word", 32'(ctr_in), 32'h3E);

        // T5: requester 1 loads zero
        bus.req_word1 = 7'h7F;
        bus.req_rpt1  = 4'd0;
        bus.req_valid = 2'b10;
        #1;
        chk("t5_ready", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            chk("t5_setup", 32'(ctr_in), 32'h7F);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            chk("t5_strobe", 32'(ctr_in), 32'hFF);
            tick();
        end
        chk("t5_capt_ctr", 32'(ctr_in), 32'h7F);
        tick();
        chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t5_rsp_id", 32'(bus.rsp_id), 32'd1);
        chk("t5_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("t5_rsp_last", 32'(bus.rsp_last), 32'd1);
        tick();
        chk("t5_idle_ctr", 32'(ctr_in), 32'h7F);
        chk("t5_busy", 32'(busy), 32'd0);

        // T3: both held valid, single ops alternate 0,1,0,1
        bus.req_word0 = 7'h3E;
        bus.req_rpt0  = 4'd0;
        bus.req_word1 = 7'h15;
        bus.req_rpt1  = 4'd0;
        bus.req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk("t3_grant", 32'(bus.req_ready), (g % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            chk("t3_ready_busy", 32'(bus.req_ready), 32'd0);
            for (int k = 1; k <= 9; k++) begin
                tick();
                if (k < 9) chk("t3_no_rsp", 32'(bus.rsp_valid), 32'd0);
            end
            chk("t3_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("t3_rsp_id", 32'(bus.rsp_id), 32'(g % 2));
            chk("t3_rsp_data", 32'(bus.rsp_data), (g < 2) ? 32'd1 : 32'd2);
            chk("t3_rsp_last", 32'(bus.rsp_last), 32'd1);
        end
        bus.req_valid = 2'b00;
        tick();

        // T4: reset during the 2nd strobe clock; request still pending afterwards
        bus.req_word0 = 7'h3E;
        bus.req_rpt0  = 4'd0;
        bus.req_valid = 2'b01;
        tick();
        repeat (5) tick();
        chk("t4_in_strobe", 32'(ctr_in), 32'hBE);
        rst = 1'b1;
        #1;
        chk("t4_abort_ctr", 32'(ctr_in), 32'h00);
        chk("t4_abort_busy", 32'(busy), 32'd1);
        chk("t4_abort_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("t4_abort_ready", 32'(bus.req_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_init_s", 32'(ctr_in), 32'h00);
            chk("t4_no_rsp", 32'(bus.rsp_valid), 32'd0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            chk("t4_init_c", 32'(ctr_in), 32'h80);
            tick();
        end
        chk("t4_idle_busy", 32'(busy), 32'd0);
        chk("t4_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 2'b00;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k < 9) chk("t4_no_rsp2", 32'(bus.rsp_valid), 32'd0);
        end
        chk("t4_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t4_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("t4_rsp_data", 32'(bus.rsp_data), 32'd4);
        chk("t4_rsp_last", 32'(bus.rsp_last), 32'd1);

        // T6: 1/1 timing, three 3-clock ops from requester 1
        fbus.req_word1 = 7'h3E;
        fbus.req_rpt1  = 4'd2;
        fbus.req_valid = 2'b10;
        #1;
        chk("t6_ready", 32'(fbus.req_ready), 32'h2);
        tick();
        fbus.req_valid = 2'b00;
        for (int op = 0; op < 3; op++) begin
            chk("t6_setup", 32'(fast_ctr_in), 32'h3E);
            tick();
            chk("t6_strobe", 32'(fast_ctr_in), 32'hBE);
            tick();
            chk("t6_capt", 32'(fast_ctr_in), 32'h3E);
            chk("t6_capt_norsp", 32'(fbus.rsp_valid), 32'd0);
            tick();
            chk("t6_rsp_valid", 32'(fbus.rsp_valid), 32'd1);
            chk("t6_rsp_id", 32'(fbus.rsp_id), 32'd1);
            chk("t6_rsp_data", 32'(fbus.rsp_data), 32'h9);
            chk("t6_rsp_last", 32'(fbus.rsp_last), (op == 2) ? 32'd1 : 32'd0);
        end
        chk("t6_busy_low", 32'(fast_busy), 32'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
